// File: rtl/bp_be_pkg.sv
// bp_be_pkg: integer register format types, processor configs and tag width helper
package bp_be_pkg;
  typedef enum logic [0:0] {e_bp_default_cfg} bp_params_e;
  localparam int cfg_dword_width_gp [1] = '{64};
  typedef enum logic [1:0] {
    e_int_byte  = 2'd0,
    e_int_hword = 2'd1,
    e_int_word  = 2'd2,
    e_int_dword = 2'd3
  } bp_be_int_tag_e;
  typedef struct packed {
    bp_be_int_tag_e tag;
    logic [63:0]    val;
  } bp_be_int_reg_s;
  function automatic int bp_int_tag_width(bp_be_int_tag_e tag);
    return 8 << tag;
  endfunction
endpackage

// File: rtl/bp_be_int_unbox.sv
// bp_be_int_unbox: combinational unbox of a tagged integer register to a raw dword
module bp_be_int_unbox
  import bp_be_pkg::*;
 (input  bp_be_int_reg_s reg_i,
  input  bp_be_int_tag_e req_tag_i,
  input  logic           unsigned_i,
  output logic [63:0]    raw_o,
  output logic           narrow_o);
  bp_be_int_tag_e eff;
  logic [63:0] mask;
  logic s;
  always_comb begin
    eff = (req_tag_i < reg_i.tag) ? req_tag_i : reg_i.tag;
    mask = {64{1'b1}} >> (64 - bp_int_tag_width(eff));
    // a boxed sub-dword keeps its sign in val[63]; truncation takes the new top bit
    s = (eff == reg_i.tag && reg_i.tag != e_int_dword) ? reg_i.val[63] : |(reg_i.val & mask & ~(mask >> 1));
    raw_o = (reg_i.val & mask) | ({64{s & ~unsigned_i}} & ~mask);
    narrow_o = req_tag_i < reg_i.tag;
  end
endmodule

// File: rtl/bp_be_int_unbox_pipe.sv
// bp_be_int_unbox_pipe: registered unbox stage with els_p-entry output FIFO.
// BP_BE_INT_UNBOX_MISMATCH_CNT_EN adds a saturating count of truncating unboxes.
module bp_be_int_unbox_pipe
  import bp_be_pkg::*;
 #(parameter bp_params_e bp_params_p = e_bp_default_cfg,
   parameter int els_p = 2,
   localparam int dword_width_gp = cfg_dword_width_gp[bp_params_p],
   localparam int dpath_width_gp = dword_width_gp + $bits(bp_be_int_tag_e))
  (input  logic                               clk_i,
   input  logic                               reset_n_i,
   input  logic [dpath_width_gp-1:0]          reg_i,
   input  logic [$bits(bp_be_int_tag_e)-1:0]  req_tag_i,
   input  logic                               unsigned_i,
   input  logic                               v_i,
   output logic                               ready_and_o,
   output logic [dword_width_gp-1:0]          raw_o,
   output logic                               narrow_o,
   output logic                               v_o,
   input  logic                               yumi_i,
   output logic [15:0]                        mismatch_cnt_o);
  localparam int pw_lp = $clog2(els_p);
  localparam int cw_lp = $clog2(els_p + 1);
  localparam logic [pw_lp-1:0] last_lp = pw_lp'(els_p - 1);
  localparam logic [cw_lp-1:0] full_lp = cw_lp'(els_p);
  typedef struct packed {
    logic [dword_width_gp-1:0] raw;
    logic                      narrow;
  } entry_s;
  entry_s mem [els_p];
  entry_s unboxed;
  bp_be_int_reg_s reg_s;
  logic [pw_lp-1:0] wptr, rptr;
  logic [cw_lp-1:0] cnt;
  logic enq, deq;
  assign reg_s = reg_i;
  bp_be_int_unbox unbox (
    .reg_i(reg_s),
    .req_tag_i(bp_be_int_tag_e'(req_tag_i)),
    .unsigned_i,
    .raw_o(unboxed.raw),
    .narrow_o(unboxed.narrow));
  assign v_o = cnt != '0;
  assign ready_and_o = cnt != full_lp;
  assign enq = v_i & ready_and_o;
  assign deq = yumi_i & v_o;
  assign raw_o = mem[rptr].raw;
  assign narrow_o = mem[rptr].narrow;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
      for (int i = 0; i < els_p; i++) mem[i] <= '0;
    end else begin
      if (enq) begin
        mem[wptr] <= unboxed;
        wptr <= (wptr == last_lp) ? '0 : wptr + pw_lp'(1);
      end
      if (deq) rptr <= (rptr == last_lp) ? '0 : rptr + pw_lp'(1);
      cnt <= cnt + cw_lp'(enq) - cw_lp'(deq);
    end
`ifdef BP_BE_INT_UNBOX_MISMATCH_CNT_EN
  logic [15:0] mcnt;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) mcnt <= '0;
    else if (enq & unboxed.narrow & ~&mcnt) mcnt <= mcnt + 16'd1;
  assign mismatch_cnt_o = mcnt;
`else
  assign mismatch_cnt_o = '0;
`endif
`ifndef SYNTHESIS
  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
`endif
endmodule

// File: tb/tb_bp_be_int_unbox_pipe.sv
// tb_bp_be_int_unbox_pipe: directed checks of unbox function, latency, buffering and reset
module tb_bp_be_int_unbox_pipe;
  import bp_be_pkg::*;
  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  logic [65:0] reg_i = '0;
  logic [1:0] req_tag_i = '0;
  logic unsigned_i = 1'b0;
  logic v_i = 1'b0;
  logic yumi_i = 1'b0;
  logic ready_and_o, narrow_o, v_o;
  logic [63:0] raw_o;
  logic [15:0] mismatch_cnt_o;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {
    logic [1:0]  tag;
    logic [63:0] val;
    logic [1:0]  req;
    logic        uns;
    logic [63:0] raw;
    logic        narrow;
  } vec_s;
  vec_s vecs [7];
`ifdef BP_BE_INT_UNBOX_MISMATCH_CNT_EN
  localparam logic [15:0] exp_cnt_lp = 16'd2;
`else
  localparam logic [15:0] exp_cnt_lp = 16'd0;
`endif
  bp_be_int_unbox_pipe dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .reg_i(reg_i),
    .req_tag_i(req_tag_i),
    .unsigned_i(unsigned_i),
    .v_i(v_i),
    .ready_and_o(ready_and_o),
    .raw_o(raw_o),
    .narrow_o(narrow_o),
    .v_o(v_o),
    .yumi_i(yumi_i),
    .mismatch_cnt_o(mismatch_cnt_o));
  always #5 clk_i = ~clk_i;
  task automatic test_reset;
    #12;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    n_checks++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL reset_v_o: got %b want 0", v_o); end
    n_checks++; if (ready_and_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready_and_o); end
    n_checks++; if (raw_o !== 64'h0) begin n_fail++; $display("FAIL reset_raw: got %h want 0", raw_o); end
    n_checks++; if (narrow_o !== 1'b0) begin n_fail++; $display("FAIL reset_narrow: got %b want 0", narrow_o); end
    n_checks++; if (mismatch_cnt_o !== 16'h0) begin n_fail++; $display("FAIL reset_mcnt: got %h want 0", mismatch_cnt_o); end
  endtask
  task automatic test_unbox;
    vecs[0] = '{2'd2, 64'h8000_0000_8000_0001, 2'd2, 1'b0, 64'hFFFF_FFFF_8000_0001, 1'b0};
    vecs[1] = '{2'd2, 64'h8000_0000_8000_0001, 2'd2, 1'b1, 64'h0000_0000_8000_0001, 1'b0};
    vecs[2] = '{2'd3, 64'h0000_0000_0000_0080, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 1'b1};
    vecs[3] = '{2'd0, 64'h0000_0000_0000_007F, 2'd3, 1'b0, 64'h0000_0000_0000_007F, 1'b0};
    vecs[4] = '{2'd0, 64'h8000_0000_0000_0001, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FF01, 1'b0};
    vecs[5] = '{2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[6] = '{2'd1, 64'h0000_0000_1234_8765, 2'd0, 1'b0, 64'h0000_0000_0000_0065, 1'b1};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i);
      reg_i = {vecs[i].tag, vecs[i].val};
      req_tag_i = vecs[i].req;
      unsigned_i = vecs[i].uns;
      v_i = 1'b1;
      n_checks++; if (ready_and_o !== 1'b1) begin n_fail++; $display("FAIL unbox%0d_ready: got %b want 1", i, ready_and_o); end
      @(negedge clk_i);
      v_i = 1'b0;
      n_checks++; if (v_o !== 1'b1) begin n_fail++; $display("FAIL unbox%0d_latency_v_o: got %b want 1", i, v_o); end
      n_checks++; if (raw_o !== vecs[i].raw) begin n_fail++; $display("FAIL unbox%0d_raw: got %h want %h", i, raw_o, vecs[i].raw); end
      n_checks++; if (narrow_o !== vecs[i].narrow) begin n_fail++; $display("FAIL unbox%0d_narrow: got %b want %b", i, narrow_o, vecs[i].narrow); end
      yumi_i = 1'b1;
      @(negedge clk_i);
      yumi_i = 1'b0;
      n_checks++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL unbox%0d_drain_v_o: got %b want 0", i, v_o); end
    end
    n_checks++; if (mismatch_cnt_o !== exp_cnt_lp) begin n_fail++; $display("FAIL mismatch_cnt: got %0d want %0d", mismatch_cnt_o, exp_cnt_lp); end
  endtask
  task automatic test_back_to_back;
    req_tag_i = 2'd3;
    unsigned_i = 1'b0;
    yumi_i = 1'b0;
    @(negedge clk_i);
    reg_i = {2'd3, 64'h1111}; v_i = 1'b1;
    n_checks++; if (ready_and_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_a: got %b want 1", ready_and_o); end
    @(negedge clk_i);
    reg_i = {2'd3, 64'h2222};
    n_checks++; if (ready_and_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_b: got %b want 1", ready_and_o); end
    n_checks++; if (raw_o !== 64'h1111) begin n_fail++; $display("FAIL b2b_head_a: got %h want 1111", raw_o); end
    @(negedge clk_i);
    reg_i = {2'd3, 64'h3333};
    n_checks++; if (ready_and_o !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got %b want 0", ready_and_o); end
    @(negedge clk_i);
    n_checks++; if (ready_and_o !== 1'b0) begin n_fail++; $display("FAIL b2b_full_hold: got %b want 0", ready_and_o); end
    n_checks++; if (raw_o !== 64'h1111) begin n_fail++; $display("FAIL b2b_out_a: got %h want 1111", raw_o); end
    yumi_i = 1'b1;
    @(negedge clk_i);
    n_checks++; if (v_o !== 1'b1) begin n_fail++; $display("FAIL b2b_v_b: got %b want 1", v_o); end
    n_checks++; if (raw_o !== 64'h2222) begin n_fail++; $display("FAIL b2b_out_b: got %h want 2222", raw_o); end
    n_checks++; if (ready_and_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_c: got %b want 1", ready_and_o); end
    @(negedge clk_i);
    v_i = 1'b0;
    n_checks++; if (v_o !== 1'b1) begin n_fail++; $display("FAIL b2b_v_c: got %b want 1", v_o); end
    n_checks++; if (raw_o !== 64'h3333) begin n_fail++; $display("FAIL b2b_out_c: got %h want 3333", raw_o); end
    n_checks++; if (ready_and_o !== 1'b1) begin n_fail++; $display("FAIL b2b_occ_one: got %b want 1", ready_and_o); end
    @(negedge clk_i);
    yumi_i = 1'b0;
    n_checks++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL b2b_no_dup: got %b want 0", v_o); end
  endtask
  task automatic test_reset_midstream;
    req_tag_i = 2'd3;
    @(negedge clk_i);
    reg_i = {2'd3, 64'hDEAD}; v_i = 1'b1;
    @(negedge clk_i);
    reg_i = {2'd3, 64'hBEEF};
    @(negedge clk_i);
    v_i = 1'b0;
    n_checks++; if (v_o !== 1'b1) begin n_fail++; $display("FAIL mid_buffered_v: got %b want 1", v_o); end
    n_checks++; if (ready_and_o !== 1'b0) begin n_fail++; $display("FAIL mid_buffered_full: got %b want 0", ready_and_o); end
    #2 reset_n_i = 1'b0;
    #1;
    n_checks++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL async_v_o: got %b want 0", v_o); end
    n_checks++; if (ready_and_o !== 1'b1) begin n_fail++; $display("FAIL async_ready: got %b want 1", ready_and_o); end
    n_checks++; if (raw_o !== 64'h0) begin n_fail++; $display("FAIL async_raw: got %h want 0", raw_o); end
    n_checks++; if (mismatch_cnt_o !== 16'h0) begin n_fail++; $display("FAIL async_mcnt: got %h want 0", mismatch_cnt_o); end
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    n_checks++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_v_o: got %b want 0", v_o); end
    n_checks++; if (ready_and_o !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", ready_and_o); end
    reg_i = {2'd3, 64'h5555}; v_i = 1'b1;
    @(negedge clk_i);
    v_i = 1'b0;
    n_checks++; if (raw_o !== 64'h5555) begin n_fail++; $display("FAIL post_reset_first: got %h want 5555", raw_o); end
    yumi_i = 1'b1;
    @(negedge clk_i);
    yumi_i = 1'b0;
    n_checks++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_stale: got %b want 0", v_o); end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, bench did not finish");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_unbox;
    test_back_to_back;
    test_reset_midstream;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
